systolic_tile_scheduler: RTL and testbench
==========================================

Name: systolic_tile_scheduler

Overview:
- Sequences a tiled matrix multiply C = A·B on the NxN systolic array top, where A has M×K tiles and B has K×P tiles.
- Per tile step it:
  - requests operand tiles from the fetch unit,
  - pulses the array's valid-input,
  - waits for the array's valid-result,
  - drives the external accumulator,
  - then hands each finished C tile to the write-back unit.
- Sits between the job/command interface and the array, fetch unit, accumulator and write-back unit.

Parameters:
- N, 8, array dimension; sets the watchdog default only.
- DIM_W, 8, width of tile counts/indices.
- WATCHDOG, 3*N+16, maximum WAIT cycles before error; must be > 3*N+2.

Ports:
- i_clk  in  1  clock
- i_arst  in  1  asynchronous active-high reset
- i_start  in  1  job start; sampled only in IDLE
- i_mTiles, i_kTiles, i_pTiles  in  DIM_W each  tile counts, latched on accepted start
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse at job end (normal or error)
- o_error  out  1  sticky error flag; cleared on next accepted start
- o_fetchReq  out  1  fetch request
- o_fetchM, o_fetchK, o_fetchP  out  DIM_W each  A tile = (m,k), B tile = (k,p)
- i_fetchAck  in  1  fetch complete
- o_saValidInput  out  1  one-cycle load pulse to the array
- i_saValidResult  in  1  array result valid
- o_accEn  out  1  accumulate-strobe pulse
- o_accClear  out  1  qualifies o_accEn: overwrite instead of add
- o_wrValid  out  1  C tile ready
- o_wrM, o_wrP  out  DIM_W each  C tile index
- i_wrReady  in  1  write-back accept

Behaviour:
- Reset (async, immediate): state=IDLE, all indices/counters=0, all outputs 0.
  - Reset mid-job aborts the job.
  - No o_done is generated for an aborted job.
- Loop order: m outer, p middle, k inner. Indices m, p, k are zero-based.
- States and transitions:
  - IDLE: on i_start, if any tile count is 0:
    - set o_error=1,
    - go to DONE.
  - IDLE: on i_start with all counts nonzero:
    - latch counts,
    - set m=p=k=0,
    - clear o_error,
    - go to FETCH.
  - FETCH: o_fetchReq=1 with stable indices until i_fetchAck=1 is sampled at a clock edge, then go to ISSUE.
    - Ack may arrive in the first FETCH cycle.
    - Ack outside FETCH is ignored.
  - ISSUE: o_saValidInput=1 for exactly one cycle, then go to WAIT. The watchdog counter clears.
  - WAIT: the counter increments each cycle.
    - i_saValidResult=1 → go to ACC. This has priority over timeout in the same cycle.
    - Counter reaches WATCHDOG-1 without a result → set o_error=1, go to DONE.
    - i_saValidResult outside WAIT is ignored.
  - ACC: o_accEn=1 for one cycle; o_accClear=(k==0).
    - If k<K-1: k++, go to FETCH.
    - Otherwise go to WRITE.
  - WRITE: o_wrValid=1 with o_wrM=m, o_wrP=p held stable until i_wrReady=1 at an edge. Then:
    - k=0;
    - if p<P-1, p++ and go to FETCH;
    - else if m<M-1, p=0, m++ and go to FETCH;
    - else go to DONE.
  - DONE: o_done=1 for one cycle, then go to IDLE.
- i_start while busy is ignored; no queuing.
- Indices are compared against latched counts; input count changes after start have no effect.
- Index increments never exceed count-1, so there is no wrap beyond the last tile.
- Per C tile: exactly K fetches, K issues, K accEn; exactly 1 accClear (first) and 1 write.
- Job totals: M·P·K fetches/issues, M·P writes.
- Minimum cycles per k-step with immediate ack and result latency L (cycles from issue pulse to result):
  - FETCH 1 + ISSUE 1 + WAIT L + ACC 1.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.

Test Plan:
- M=K=P=1, ack same cycle, result 26 cycles after issue, ready high:
  - exactly 1 fetchReq, 1 saValidInput, 1 accEn with accClear=1, 1 wrValid(m=0,p=0), 1 done;
  - o_error=0; o_busy high from the cycle after start until done.
- M=K=P=2:
  - 8 fetch triples in order (0,0,0),(0,1,0),(0,0,1),(0,1,1),(1,0,0),(1,1,0),(1,0,1),(1,1,1) as (m,k,p);
  - accClear pattern 1,0 repeating;
  - writes in order (0,0),(0,1),(1,0),(1,1);
  - single done.
- Backpressure: i_fetchAck delayed 5 cycles, i_wrReady delayed 7 cycles:
  - fetchReq/indices and wrValid/indices held stable throughout;
  - no duplicate pulses;
  - counts identical to the unstalled run.
- Watchdog (N=8, WATCHDOG=40): withhold the result → o_error=1 and o_done after 40 WAIT cycles, return to IDLE.
  - Next start clears o_error.
  - Result asserted in the same cycle as timeout → treated as normal, no error.
- Start with i_kTiles=0: no fetchReq; o_error=1 and o_done the cycle after start.
- Start pulse during WAIT is ignored (job counts unchanged).
- Assert i_arst during WRITE:
  - all outputs 0 immediately (asynchronously);
  - no done;
  - a fresh start afterwards runs from tile (0,0,0).

Source files
------------

// File: rtl/systolic_tile_scheduler.sv
// Tile-step sequencer for a tiled C = A*B on an NxN systolic array.
// Walks m (outer), p (middle), k (inner) over latched tile counts and handshakes with fetch, array, accumulator and write-back.
module systolic_tile_scheduler #(
  parameter int N        = 8,
  parameter int DIM_W    = 8,
  parameter int WATCHDOG = 3*N+16
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_start,
  input  logic [DIM_W-1:0] i_mTiles,
  input  logic [DIM_W-1:0] i_kTiles,
  input  logic [DIM_W-1:0] i_pTiles,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic             o_fetchReq,
  output logic [DIM_W-1:0] o_fetchM,
  output logic [DIM_W-1:0] o_fetchK,
  output logic [DIM_W-1:0] o_fetchP,
  input  logic             i_fetchAck,
  output logic             o_saValidInput,
  input  logic             i_saValidResult,
  output logic             o_accEn,
  output logic             o_accClear,
  output logic             o_wrValid,
  output logic [DIM_W-1:0] o_wrM,
  output logic [DIM_W-1:0] o_wrP,
  input  logic             i_wrReady
);

  localparam int WD_W = $clog2(WATCHDOG);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_ACC, S_WRITE, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DIM_W-1:0] r_mt, r_kt, r_pt;
  logic [DIM_W-1:0] r_m, r_k, r_p;
  logic [WD_W-1:0]  r_wdog;
  logic             r_error;

  logic w_zero_cnt, w_k_last, w_p_last, w_m_last, w_timeout;

  assign w_zero_cnt = (i_mTiles == '0) || (i_kTiles == '0) || (i_pTiles == '0);
  assign w_k_last   = (r_k == r_kt - DIM_W'(1));
  assign w_p_last   = (r_p == r_pt - DIM_W'(1));
  assign w_m_last   = (r_m == r_mt - DIM_W'(1));
  assign w_timeout  = (r_wdog == WD_W'(WATCHDOG - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = w_zero_cnt ? S_DONE : S_FETCH;
      S_FETCH: if (i_fetchAck) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        // A result arriving on the last watchdog cycle still wins.
        if (i_saValidResult) w_next = S_ACC;
        else if (w_timeout)  w_next = S_DONE;
      end
      S_ACC:   w_next = w_k_last ? S_WRITE : S_FETCH;
      S_WRITE: if (i_wrReady) w_next = (w_p_last && w_m_last) ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_mt    <= '0;
      r_kt    <= '0;
      r_pt    <= '0;
      r_m     <= '0;
      r_k     <= '0;
      r_p     <= '0;
      r_wdog  <= '0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_zero_cnt) begin
              r_error <= 1'b1;
            end else begin
              r_mt    <= i_mTiles;
              r_kt    <= i_kTiles;
              r_pt    <= i_pTiles;
              r_m     <= '0;
              r_k     <= '0;
              r_p     <= '0;
              r_error <= 1'b0;
            end
          end
        end
        S_ISSUE: r_wdog <= '0;
        S_WAIT: begin
          if (!i_saValidResult) begin
            if (w_timeout) r_error <= 1'b1;
            else           r_wdog  <= r_wdog + WD_W'(1);
          end
        end
        S_ACC: if (!w_k_last) r_k <= r_k + DIM_W'(1);
        S_WRITE: begin
          if (i_wrReady) begin
            r_k <= '0;
            if (!w_p_last) begin
              r_p <= r_p + DIM_W'(1);
            end else if (!w_m_last) begin
              r_p <= '0;
              r_m <= r_m + DIM_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode from the state register only; indices come straight from flops.
  always_comb begin
    o_busy         = (r_state != S_IDLE);
    o_done         = (r_state == S_DONE);
    o_fetchReq     = (r_state == S_FETCH);
    o_saValidInput = (r_state == S_ISSUE);
    o_accEn        = (r_state == S_ACC);
    o_accClear     = (r_state == S_ACC) && (r_k == '0);
    o_wrValid      = (r_state == S_WRITE);
  end

  assign o_error  = r_error;
  assign o_fetchM = r_m;
  assign o_fetchK = r_k;
  assign o_fetchP = r_p;
  assign o_wrM    = r_m;
  assign o_wrP    = r_p;

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Self-checking bench: table of jobs plus random jobs against a loop-nest reference model,
// with responders for fetch/array/write-back and hand-written reset-in-WRITE sequence.
module tb_systolic_tile_scheduler;

  localparam int N     = 8;
  localparam int DIM_W = 8;
  localparam int WD    = 3*N+16;
  localparam int NEVER = 1000000;

  logic             i_clk = 1'b0;
  logic             i_arst = 1'b1;
  logic             i_start = 1'b0;
  logic [DIM_W-1:0] i_mTiles = '0, i_kTiles = '0, i_pTiles = '0;
  logic             i_fetchAck = 1'b0, i_saValidResult = 1'b0, i_wrReady = 1'b0;
  logic             o_busy, o_done, o_error, o_fetchReq, o_saValidInput;
  logic             o_accEn, o_accClear, o_wrValid;
  logic [DIM_W-1:0] o_fetchM, o_fetchK, o_fetchP, o_wrM, o_wrP;

  always #5 i_clk = ~i_clk;

  systolic_tile_scheduler #(.N(N), .DIM_W(DIM_W), .WATCHDOG(WD)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_start(i_start),
    .i_mTiles(i_mTiles), .i_kTiles(i_kTiles), .i_pTiles(i_pTiles),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_fetchReq(o_fetchReq), .o_fetchM(o_fetchM), .o_fetchK(o_fetchK), .o_fetchP(o_fetchP),
    .i_fetchAck(i_fetchAck), .o_saValidInput(o_saValidInput), .i_saValidResult(i_saValidResult),
    .o_accEn(o_accEn), .o_accClear(o_accClear),
    .o_wrValid(o_wrValid), .o_wrM(o_wrM), .o_wrP(o_wrP), .i_wrReady(i_wrReady)
  );

  logic [47:0] all_out;
  assign all_out = {o_busy, o_done, o_error, o_fetchReq, o_fetchM, o_fetchK, o_fetchP,
                    o_saValidInput, o_accEn, o_accClear, o_wrValid, o_wrM, o_wrP};

  typedef logic [3*DIM_W-1:0] trip_t;
  typedef logic [2*DIM_W-1:0] pair_t;
  typedef struct {
    int m, k, p, ad, rd, lat;
    bit poke;
    int exp_fetch, exp_wr;
    bit exp_err;
  } vec_t;

  int n_vec = 0, n_err = 0;
  int cd, fhold, whold, cur_ad, cur_rd, cur_lat;
  bit block_wr;
  trip_t exp_f[$];
  bit    exp_c[$];
  pair_t exp_w[$];
  bit    exp_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: move to the negedge, then drive responder inputs for the current DUT outputs.
  task automatic step();
    @(negedge i_clk);
    if (cd > 0) begin
      cd--;
      i_saValidResult = (cd == 0);
    end else begin
      i_saValidResult = ($urandom_range(0, 1) != 0);
    end
    if (o_saValidInput) cd = (cur_lat == 0) ? NEVER : cur_lat;
    if (o_fetchReq) begin
      i_fetchAck = (fhold >= cur_ad);
      fhold++;
    end else begin
      fhold = 0;
      i_fetchAck = ($urandom_range(0, 1) != 0);
    end
    if (o_wrValid && !block_wr) begin
      i_wrReady = (whold >= cur_rd);
      whold++;
    end else begin
      whold = 0;
      i_wrReady = block_wr ? 1'b0 : ($urandom_range(0, 1) != 0);
    end
  endtask

  // Reference: plain loop nest over the job; a late or missing result stops after one tile step.
  task automatic model(input int m, input int k, input int p, input int lat);
    exp_f.delete(); exp_c.delete(); exp_w.delete();
    if (m == 0 || k == 0 || p == 0) begin
      exp_err = 1'b1;
      return;
    end
    if (lat == 0 || lat > WD) begin
      exp_f.push_back('0);
      exp_err = 1'b1;
      return;
    end
    exp_err = 1'b0;
    for (int mi = 0; mi < m; mi++)
      for (int pi = 0; pi < p; pi++) begin
        for (int ki = 0; ki < k; ki++) begin
          exp_f.push_back({DIM_W'(mi), DIM_W'(ki), DIM_W'(pi)});
          exp_c.push_back(ki == 0);
        end
        exp_w.push_back({DIM_W'(mi), DIM_W'(pi)});
      end
  endtask

  task automatic run_job(input vec_t v);
    trip_t got_f[$];
    bit    got_c[$];
    pair_t got_w[$];
    trip_t fs;
    pair_t ws;
    int n_issue = 0, viol = 0, busy_low = 0, done_cyc = 0, last_issue = 0;
    bit pf = 0, pw = 0, pi = 0, pa = 0, poked = 0, zero;
    logic err_first = 1'b0;
    zero = (v.m == 0 || v.k == 0 || v.p == 0);
    cur_ad = v.ad; cur_rd = v.rd; cur_lat = v.lat;
    cd = 0; fhold = 0; whold = 0; block_wr = 0;
    @(negedge i_clk);
    i_start = 1'b1;
    i_mTiles = DIM_W'(v.m); i_kTiles = DIM_W'(v.k); i_pTiles = DIM_W'(v.p);
    for (int cyc = 1; cyc <= 20000; cyc++) begin
      step();
      i_start = 1'b0;
      if (cyc == 1) begin
        err_first = o_error;
        i_mTiles = DIM_W'($urandom_range(0, 9));
        i_kTiles = DIM_W'($urandom_range(0, 9));
        i_pTiles = DIM_W'($urandom_range(0, 9));
      end
      if (!o_busy) busy_low++;
      if (o_fetchReq) begin
        if (pf && {o_fetchM, o_fetchK, o_fetchP} !== fs) viol++;
        fs = {o_fetchM, o_fetchK, o_fetchP};
        if (i_fetchAck) got_f.push_back(fs);
      end
      pf = o_fetchReq;
      if (o_saValidInput) begin
        n_issue++;
        last_issue = cyc;
        if (pi) viol++;
      end
      pi = o_saValidInput;
      if (o_accEn) begin
        got_c.push_back(o_accClear);
        if (pa) viol++;
      end else if (o_accClear) begin
        viol++;
      end
      pa = o_accEn;
      if (o_wrValid) begin
        if (pw && {o_wrM, o_wrP} !== ws) viol++;
        ws = {o_wrM, o_wrP};
        if (i_wrReady) got_w.push_back(ws);
      end
      pw = o_wrValid;
      if (v.poke && !poked && cd > 0 && !o_saValidInput) begin
        i_start = 1'b1;
        i_mTiles = DIM_W'($urandom_range(1, 5));
        i_kTiles = DIM_W'($urandom_range(1, 5));
        i_pTiles = DIM_W'($urandom_range(1, 5));
        poked = 1;
      end
      if (o_done) begin
        done_cyc = cyc;
        break;
      end
    end
    check("done seen", done_cyc != 0, 1);
    step();
    check("idle after done", {o_busy, o_done}, 0);
    model(v.m, v.k, v.p, v.lat);
    check("fetch count vs table", got_f.size(), v.exp_fetch);
    check("write count vs table", got_w.size(), v.exp_wr);
    check("error vs table", o_error, v.exp_err);
    check("error vs model", o_error, exp_err);
    check("error after start", err_first, zero);
    check("issue count", n_issue, exp_f.size());
    check("acc count", got_c.size(), exp_c.size());
    check("protocol violations", {viol, busy_low}, 0);
    for (int i = 0; i < exp_f.size() && i < got_f.size(); i++)
      check($sformatf("fetch[%0d] m,k,p", i), got_f[i], exp_f[i]);
    for (int i = 0; i < exp_c.size() && i < got_c.size(); i++)
      check($sformatf("accClear[%0d]", i), got_c[i], exp_c[i]);
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      check($sformatf("write[%0d] m,p", i), got_w[i], exp_w[i]);
    if (zero)
      check("zero-count done latency", done_cyc, 1);
    else if (exp_err)
      check("watchdog issue-to-done", done_cyc - last_issue, WD + 1);
    else
      check("job cycles", done_cyc, v.m*v.p*(v.k*(3 + v.lat + v.ad) + 1 + v.rd) + 1);
  endtask

  vec_t tbl[11];
  vec_t rv;
  int   got, dn;

  initial begin
    //            m  k  p ad rd lat poke fetch wr err
    tbl[0]  = '{1, 1, 1, 0, 0, 26, 1'b0, 1, 1, 1'b0};
    tbl[1]  = '{2, 2, 2, 0, 0,  3, 1'b0, 8, 4, 1'b0};
    tbl[2]  = '{2, 2, 2, 5, 7,  3, 1'b0, 8, 4, 1'b0};
    tbl[3]  = '{1, 1, 1, 0, 0,  0, 1'b0, 1, 0, 1'b1};
    tbl[4]  = '{1, 1, 1, 0, 0, 40, 1'b0, 1, 1, 1'b0};
    tbl[5]  = '{1, 1, 1, 0, 0, 41, 1'b0, 1, 0, 1'b1};
    tbl[6]  = '{1, 0, 1, 0, 0,  3, 1'b0, 0, 0, 1'b1};
    tbl[7]  = '{3, 1, 2, 1, 2,  5, 1'b1, 6, 6, 1'b0};
    tbl[8]  = '{1, 3, 1, 2, 0,  1, 1'b0, 3, 1, 1'b0};
    tbl[9]  = '{0, 2, 2, 0, 0,  3, 1'b0, 0, 0, 1'b1};
    tbl[10] = '{2, 1, 3, 0, 1,  4, 1'b1, 6, 6, 1'b0};

    cd = 0; fhold = 0; whold = 0; block_wr = 0; cur_ad = 0; cur_rd = 0; cur_lat = 1;
    #1 check("outputs in reset", all_out, 0);
    repeat (2) @(negedge i_clk);
    i_arst = 1'b0;
    @(negedge i_clk);
    check("outputs idle after reset", all_out, 0);

    foreach (tbl[i]) run_job(tbl[i]);

    for (int r = 0; r < 30; r++) begin
      rv.m = $urandom_range(1, 3); rv.k = $urandom_range(1, 3); rv.p = $urandom_range(1, 3);
      rv.ad = $urandom_range(0, 3); rv.rd = $urandom_range(0, 3); rv.lat = $urandom_range(1, 8);
      rv.poke = ($urandom_range(0, 1) != 0) && (rv.lat >= 3);
      rv.exp_fetch = rv.m*rv.k*rv.p; rv.exp_wr = rv.m*rv.p; rv.exp_err = 1'b0;
      run_job(rv);
    end

    // Reset asserted while a C tile waits in WRITE.
    cur_ad = 0; cur_rd = 0; cur_lat = 3; cd = 0; fhold = 0; whold = 0; block_wr = 1;
    @(negedge i_clk);
    i_start = 1'b1; i_mTiles = 8'd2; i_kTiles = 8'd2; i_pTiles = 8'd1;
    got = 0;
    for (int c = 0; c < 500; c++) begin
      step();
      i_start = 1'b0;
      if (o_wrValid) begin
        got = 1;
        break;
      end
    end
    check("reached WRITE before reset", got, 1);
    #2 i_arst = 1'b1;
    #1 check("async reset clears outputs", all_out, 0);
    dn = 0;
    repeat (3) begin
      @(negedge i_clk);
      if (o_done) dn++;
    end
    i_arst = 1'b0; block_wr = 0; cd = 0;
    repeat (3) begin
      step();
      if (o_done || o_busy) dn++;
    end
    check("no done or busy after abort", dn, 0);
    run_job('{1, 2, 1, 0, 0, 2, 1'b0, 2, 1, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
